operand_fetch_stage: RTL and testbench

- Stage directly upstream of the ALU. It decodes the 32-bit instruction and reads RA/RB from a 32x32 register file, muxing a sign-extended immediate into RB.
- Registers the operand bundle (RA, RB, ALU_Op, NOP_FLAG, destination) for the ALU, accepts the ALU-result writeback (RZ) into the register file, and stalls on read-after-write hazards using a pending-write scoreboard.

---
 rtl/operand_fetch_stage_pkg.sv | 31 +++
 rtl/operand_fetch_stage_register_file_2r1w.sv | 62 ++++++
 rtl/operand_fetch_stage.sv | 114 +++++++++++
 tb/tb_operand_fetch_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_stage_pkg.sv
// Shared definitions for the operand fetch stage: instruction field positions,
// datapath sizes and the operand bundle handed to the ALU.
package operand_fetch_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;

  localparam int RS_A_MSB    = 31;
  localparam int RS_A_LSB    = 27;
  localparam int RS_B_MSB    = 26;
  localparam int RS_B_LSB    = 22;
  localparam int RD_MSB      = 21;
  localparam int RD_LSB      = 17;
  localparam int IMM_SEL_BIT = 16;
  localparam int IMM_MSB     = 15;
  localparam int IMM_LSB     = 6;
  localparam int OPCODE_MSB  = 5;
  localparam int OPCODE_LSB  = 0;

  localparam logic [5:0] NOP_OPCODE = 6'b111111;

  typedef struct packed {
    logic [DATA_W-1:0]     ra;
    logic [DATA_W-1:0]     rb;
    logic [DATA_W-1:0]     alu_op;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  nop_flag;
  } operand_bundle_t;

endpackage

// File: rtl/operand_fetch_stage_register_file_2r1w.sv
// 32x32 register file: two combinational read ports with write-through bypass,
// one synchronous write port, synchronous clear, optional hard-wired zero register.
module register_file_2r1w
  import operand_fetch_stage_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0]     rdata_a,
  output logic [DATA_W-1:0]     rdata_b
);

  logic [REG_COUNT-1:0][DATA_W-1:0] mem_q;
  logic [REG_COUNT-1:0][DATA_W-1:0] mem_d;
  logic                             wr_ok_s;

  assign wr_ok_s = we & ~(ZERO_REG & (waddr == 5'd0));

  always_comb begin
    mem_d = mem_q;
    if (wr_ok_s) begin
      mem_d[waddr] = wdata;
    end else begin
      mem_d = mem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // A same-cycle write is forwarded so the reader never sees the stale value.
  always_comb begin
    rdata_a = mem_q[raddr_a];
    rdata_b = mem_q[raddr_b];
    if (ZERO_REG && (raddr_a == 5'd0)) begin
      rdata_a = 32'd0;
    end else if (wr_ok_s && (waddr == raddr_a)) begin
      rdata_a = wdata;
    end else begin
      rdata_a = mem_q[raddr_a];
    end
    if (ZERO_REG && (raddr_b == 5'd0)) begin
      rdata_b = 32'd0;
    end else if (wr_ok_s && (waddr == raddr_b)) begin
      rdata_b = wdata;
    end else begin
      rdata_b = mem_q[raddr_b];
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: decodes the instruction, reads operands, tracks pending
// writes to stall on RAW hazards, and registers the operand bundle for the ALU.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter bit         IMM_SIGNED = 1'b1,
  parameter logic [5:0] NOP_OPCODE = operand_fetch_stage_pkg::NOP_OPCODE,
  parameter bit         ZERO_REG   = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        In_Valid,
  input  logic [31:0] Instruction,
  output logic        In_Ready,
  input  logic        WB_Enable,
  input  logic [4:0]  WB_Addr,
  input  logic [31:0] WB_Data,
  input  logic        Out_Ready,
  output logic        Out_Valid,
  output logic [31:0] RA,
  output logic [31:0] RB,
  output logic [31:0] ALU_Op,
  output logic [4:0]  RD_Addr,
  output logic        NOP_FLAG
);

  logic [REG_ADDR_W-1:0] rs_a_s, rs_b_s, rd_s;
  logic                  imm_sel_s, is_nop_s;
  logic [9:0]            imm10_s;
  logic [DATA_W-1:0]     imm_ext_s, rdata_a_s, rdata_b_s;
  logic                  pend_a_s, pend_b_s, hazard_s, fire_in_s;

  logic [REG_COUNT-1:0]  pending_q, pending_d;
  logic                  out_valid_q, out_valid_d;
  operand_bundle_t       bundle_q, bundle_d;

  assign rs_a_s    = Instruction[RS_A_MSB:RS_A_LSB];
  assign rs_b_s    = Instruction[RS_B_MSB:RS_B_LSB];
  assign rd_s      = Instruction[RD_MSB:RD_LSB];
  assign imm_sel_s = Instruction[IMM_SEL_BIT];
  assign imm10_s   = Instruction[IMM_MSB:IMM_LSB];
  assign is_nop_s  = (Instruction[OPCODE_MSB:OPCODE_LSB] == NOP_OPCODE);
  assign imm_ext_s = IMM_SIGNED ? {{22{imm10_s[9]}}, imm10_s} : {22'd0, imm10_s};

  register_file_2r1w #(.ZERO_REG(ZERO_REG)) u_rf (
    .clk     (Clock),
    .rst     (Reset),
    .we      (WB_Enable),
    .waddr   (WB_Addr),
    .wdata   (WB_Data),
    .raddr_a (rs_a_s),
    .raddr_b (rs_b_s),
    .rdata_a (rdata_a_s),
    .rdata_b (rdata_b_s)
  );

  // A writeback landing this cycle releases its register immediately.
  assign pend_a_s  = pending_q[rs_a_s] & ~(WB_Enable & (WB_Addr == rs_a_s));
  assign pend_b_s  = pending_q[rs_b_s] & ~(WB_Enable & (WB_Addr == rs_b_s));
  assign hazard_s  = In_Valid & (pend_a_s | (~imm_sel_s & pend_b_s));
  assign In_Ready  = (~out_valid_q | Out_Ready) & ~hazard_s;
  assign fire_in_s = In_Valid & In_Ready;

  always_comb begin
    pending_d = pending_q;
    if (WB_Enable) begin
      pending_d[WB_Addr] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (fire_in_s && !is_nop_s && !(ZERO_REG && (rd_s == 5'd0))) begin
      pending_d[rd_s] = 1'b1;
    end else begin
      pending_d[rd_s] = pending_d[rd_s];
    end
  end

  always_comb begin
    bundle_d    = bundle_q;
    out_valid_d = out_valid_q;
    if (fire_in_s) begin
      out_valid_d       = 1'b1;
      bundle_d.ra       = rdata_a_s;
      bundle_d.rb       = imm_sel_s ? imm_ext_s : rdata_b_s;
      bundle_d.alu_op   = Instruction;
      bundle_d.rd_addr  = rd_s;
      bundle_d.nop_flag = is_nop_s;
    end else if (out_valid_q && Out_Ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  assign Out_Valid = out_valid_q;
  assign RA        = bundle_q.ra;
  assign RB        = bundle_q.rb;
  assign ALU_Op    = bundle_q.alu_op;
  assign RD_Addr   = bundle_q.rd_addr;
  assign NOP_FLAG  = bundle_q.nop_flag;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage; a second instance with zero-extended
// immediates shares the stimulus.
module tb_operand_fetch_stage;

  logic        Clock = 1'b0;
  logic        Reset, In_Valid, WB_Enable, Out_Ready;
  logic [31:0] Instruction, WB_Data;
  logic [4:0]  WB_Addr;

  logic        In_Ready, Out_Valid, NOP_FLAG;
  logic [31:0] RA, RB, ALU_Op;
  logic [4:0]  RD_Addr;

  logic        In_Ready_u, Out_Valid_u, NOP_FLAG_u;
  logic [31:0] RA_u, RB_u, ALU_Op_u;
  logic [4:0]  RD_Addr_u;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] held_op;
  logic [31:0] instr_x;

  always #5 Clock = ~Clock;

  operand_fetch_stage #(.IMM_SIGNED(1'b1), .NOP_OPCODE(6'b111111), .ZERO_REG(1'b1)) dut (
    .Clock(Clock), .Reset(Reset), .In_Valid(In_Valid), .Instruction(Instruction),
    .In_Ready(In_Ready), .WB_Enable(WB_Enable), .WB_Addr(WB_Addr), .WB_Data(WB_Data),
    .Out_Ready(Out_Ready), .Out_Valid(Out_Valid), .RA(RA), .RB(RB), .ALU_Op(ALU_Op),
    .RD_Addr(RD_Addr), .NOP_FLAG(NOP_FLAG)
  );

  operand_fetch_stage #(.IMM_SIGNED(1'b0), .NOP_OPCODE(6'b111111), .ZERO_REG(1'b1)) dut_u (
    .Clock(Clock), .Reset(Reset), .In_Valid(In_Valid), .Instruction(Instruction),
    .In_Ready(In_Ready_u), .WB_Enable(WB_Enable), .WB_Addr(WB_Addr), .WB_Data(WB_Data),
    .Out_Ready(Out_Ready), .Out_Valid(Out_Valid_u), .RA(RA_u), .RB(RB_u), .ALU_Op(ALU_Op_u),
    .RD_Addr(RD_Addr_u), .NOP_FLAG(NOP_FLAG_u)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [4:0] rs_a, input logic [4:0] rs_b,
                                           input logic [4:0] rd, input logic imm_sel,
                                           input logic [9:0] imm10, input logic [5:0] op);
    return {rs_a, rs_b, rd, imm_sel, imm10, op};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset = 1'b1; In_Valid = 1'b0; Instruction = 32'd0; WB_Enable = 1'b0;
    WB_Addr = 5'd0; WB_Data = 32'd0; Out_Ready = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    #1;
    check_eq("rst_out_valid", {31'd0, Out_Valid}, 32'd0);
    check_eq("rst_ra", RA, 32'd0);
    check_eq("rst_alu_op", ALU_Op, 32'd0);
    check_eq("rst_in_ready", {31'd0, In_Ready}, 32'd1);

    // write R5 then read it
    WB_Enable = 1'b1; WB_Addr = 5'd5; WB_Data = 32'h0000_0010;
    tick();
    WB_Enable = 1'b0;
    Instruction = mk_instr(5'd5, 5'd0, 5'd1, 1'b0, 10'd0, 6'h01);
    In_Valid = 1'b1;
    tick();
    In_Valid = 1'b0;
    check_eq("add_valid", {31'd0, Out_Valid}, 32'd1);
    check_eq("add_ra", RA, 32'h10);
    check_eq("add_rb", RB, 32'd0);
    check_eq("add_nop", {31'd0, NOP_FLAG}, 32'd0);
    check_eq("add_rd", {27'd0, RD_Addr}, 32'd1);
    check_eq("add_op", ALU_Op, mk_instr(5'd5, 5'd0, 5'd1, 1'b0, 10'd0, 6'h01));
    tick();
    check_eq("drain_valid", {31'd0, Out_Valid}, 32'd0);

    // immediates, signed and zero extended
    Instruction = mk_instr(5'd0, 5'd9, 5'd0, 1'b1, 10'h3FF, 6'h02);
    In_Valid = 1'b1;
    tick();
    check_eq("imm3ff_s", RB, 32'hFFFF_FFFF);
    check_eq("imm3ff_u", RB_u, 32'h0000_03FF);
    check_eq("imm_ra_r0", RA, 32'd0);
    Instruction = mk_instr(5'd0, 5'd0, 5'd0, 1'b1, 10'h200, 6'h02);
    tick();
    check_eq("imm200_s", RB, 32'hFFFF_FE00);
    check_eq("imm200_u", RB_u, 32'h0000_0200);
    Instruction = mk_instr(5'd0, 5'd0, 5'd0, 1'b1, 10'h155, 6'h02);
    tick();
    check_eq("imm155_s", RB, 32'h0000_0155);
    In_Valid = 1'b0;
    tick();

    // RAW stall on R3, released by writeback with bypass
    Instruction = mk_instr(5'd0, 5'd0, 5'd3, 1'b0, 10'd0, 6'h01);
    In_Valid = 1'b1;
    tick();
    Instruction = mk_instr(5'd3, 5'd0, 5'd4, 1'b0, 10'd0, 6'h01);
    #1;
    check_eq("raw_stall0", {31'd0, In_Ready}, 32'd0);
    tick();
    check_eq("raw_stall1", {31'd0, In_Ready}, 32'd0);
    check_eq("raw_drained", {31'd0, Out_Valid}, 32'd0);
    WB_Enable = 1'b1; WB_Addr = 5'd3; WB_Data = 32'h0000_ABCD;
    #1;
    check_eq("raw_release", {31'd0, In_Ready}, 32'd1);
    tick();
    WB_Enable = 1'b0;
    check_eq("raw_valid", {31'd0, Out_Valid}, 32'd1);
    check_eq("raw_bypass_ra", RA, 32'h0000_ABCD);

    // backpressure: bundle must hold for three cycles
    held_op = mk_instr(5'd3, 5'd0, 5'd4, 1'b0, 10'd0, 6'h01);
    instr_x = mk_instr(5'd5, 5'd3, 5'd6, 1'b0, 10'd0, 6'h03);
    Out_Ready = 1'b0;
    Instruction = instr_x;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("bp_in_ready", {31'd0, In_Ready}, 32'd0);
      tick();
      check_eq("bp_hold_op", ALU_Op, held_op);
      check_eq("bp_hold_ra", RA, 32'h0000_ABCD);
      check_eq("bp_hold_valid", {31'd0, Out_Valid}, 32'd1);
    end
    Out_Ready = 1'b1;
    #1;
    check_eq("bp_release", {31'd0, In_Ready}, 32'd1);
    tick();
    In_Valid = 1'b0;
    check_eq("bp_next_op", ALU_Op, instr_x);
    check_eq("bp_next_ra", RA, 32'h10);
    check_eq("bp_next_rb", RB, 32'h0000_ABCD);
    tick();
    check_eq("bp_no_dup", {31'd0, Out_Valid}, 32'd0);

    // NOP with rd=7 must not mark R7 pending
    Instruction = mk_instr(5'd0, 5'd0, 5'd7, 1'b0, 10'd0, 6'h3F);
    In_Valid = 1'b1;
    tick();
    check_eq("nop_flag", {31'd0, NOP_FLAG}, 32'd1);
    check_eq("nop_rd", {27'd0, RD_Addr}, 32'd7);
    Instruction = mk_instr(5'd7, 5'd0, 5'd0, 1'b0, 10'd0, 6'h01);
    #1;
    check_eq("nop_no_stall", {31'd0, In_Ready}, 32'd1);
    tick();
    check_eq("after_nop_flag", {31'd0, NOP_FLAG}, 32'd0);
    check_eq("after_nop_ra", RA, 32'd0);

    // writes to R0 are ignored, including the bypass path
    WB_Enable = 1'b1; WB_Addr = 5'd0; WB_Data = 32'h0000_FFFF;
    Instruction = mk_instr(5'd0, 5'd0, 5'd0, 1'b0, 10'd0, 6'h01);
    tick();
    WB_Enable = 1'b0;
    check_eq("r0_bypass_ra", RA, 32'd0);
    tick();
    check_eq("r0_later_ra", RA, 32'd0);
    In_Valid = 1'b0;
    tick();

    // reset in the middle of a stall with a held bundle
    Out_Ready = 1'b0;
    Instruction = mk_instr(5'd5, 5'd0, 5'd8, 1'b0, 10'd0, 6'h01);
    In_Valid = 1'b1;
    tick();
    Instruction = mk_instr(5'd6, 5'd0, 5'd0, 1'b0, 10'd0, 6'h01);
    #1;
    check_eq("pre_rst_stall", {31'd0, In_Ready}, 32'd0);
    Reset = 1'b1; WB_Enable = 1'b1; WB_Addr = 5'd9; WB_Data = 32'h0000_0099;
    tick();
    Reset = 1'b0; WB_Enable = 1'b0; In_Valid = 1'b0;
    check_eq("mid_rst_valid", {31'd0, Out_Valid}, 32'd0);
    check_eq("mid_rst_op", ALU_Op, 32'd0);
    check_eq("mid_rst_rd", {27'd0, RD_Addr}, 32'd0);
    Out_Ready = 1'b1;
    Instruction = mk_instr(5'd6, 5'd4, 5'd0, 1'b0, 10'd0, 6'h01);
    In_Valid = 1'b1;
    #1;
    check_eq("pending_cleared", {31'd0, In_Ready}, 32'd1);
    tick();
    Instruction = mk_instr(5'd5, 5'd9, 5'd0, 1'b0, 10'd0, 6'h01);
    tick();
    In_Valid = 1'b0;
    check_eq("rf_cleared_ra", RA, 32'd0);
    check_eq("rst_wb_ignored_rb", RB, 32'd0);
    check_eq("post_rst_valid", {31'd0, Out_Valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
